regfile_2r1w: RTL and testbench

Parametrised register file with one write port and two read ports, generalising the fixed 32-input, 32-bit read multiplexer into a complete storage block. It sits between decode and execute in the datapath. Reads are registered (1-cycle latency) with write-to-read bypass. Register 0 can optionally be hardwired to zero. Width, depth and the zero-register mode are parameters.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_rd_port.sv | 68 ++++++
 rtl/regfile_2r1w.sv | 66 ++++++
 tb/tb_regfile_2r1w.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the 2-read / 1-write register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: NUM_REGS:1 mux, write bypass, output register.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REGS-1:0][DATA_W-1:0] mem,
    input  logic                           wen,
    input  logic [ADDR_W-1:0]              waddr,
    input  logic [DATA_W-1:0]              wdata,
    input  logic                           re,
    input  logic [ADDR_W-1:0]              raddr,
    output logic [DATA_W-1:0]              rdata,
    output logic                           rvalid
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] rnext;
    logic              in_range;
    logic              is_zero;
    logic              hit;

    assign in_range = {1'b0, raddr} < LIMIT;
    assign is_zero  = (ZERO_REG != 0) && (raddr == ADDR_W'(ZERO_ADDR));
    // wen is already qualified, so a dropped write never bypasses
    assign hit      = (BYPASS != 0) && wen && (waddr == raddr);

    always_comb begin
        stored = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr == ADDR_W'(i)) begin
                stored = mem[i];
            end
        end
    end

    always_comb begin
        rnext = stored;
        if (!in_range) begin
            rnext = '0;
        end else if (is_zero) begin
            rnext = '0;
        end else if (hit) begin
            rnext = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= rnext;
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file: one write port, two registered read ports.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem;
    logic                            wen;

    assign wen = we && ({1'b0, waddr} < LIMIT) &&
                 !((ZERO_REG != 0) && (waddr == ADDR_W'(ZERO_ADDR)));

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (wen) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    regfile_rd_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_port_a (
        .clk(clk), .rst(rst), .mem(mem),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .re(re_a), .raddr(raddr_a),
        .rdata(rdata_a), .rvalid(rvalid_a)
    );

    regfile_rd_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_port_b (
        .clk(clk), .rst(rst), .mem(mem),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .re(re_b), .raddr(raddr_b),
        .rdata(rdata_b), .rvalid(rvalid_b)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench: default instance u0, and u1 with 20 regs,
// no zero register and no bypass, sharing the same stimulus.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re_a = 1'b0;
    logic [4:0]  raddr_a = '0;
    logic        re_b = 1'b0;
    logic [4:0]  raddr_b = '0;

    logic [31:0] a0, b0, a1, b1;
    logic        va0, vb0, va1, vb1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    regfile_2r1w u0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(a0), .rvalid_a(va0),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(b0), .rvalid_b(vb0)
    );

    regfile_2r1w #(
        .NUM_REGS(20), .ZERO_REG(0), .BYPASS(0)
    ) u1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(a1), .rvalid_a(va1),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(b1), .rvalid_b(vb1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++;
        if ({a0, b0, a1, b1} !== 128'h0 || {va0, vb0, va1, vb1} !== 4'b0)
            $display("FAIL reset_outputs got %h %h %h %h v=%b want 0",
                     a0, b0, a1, b1, {va0, vb0, va1, vb1});
        else passed++;
        for (int i = 0; i < 32; i++) begin
            re_a = 1'b1; re_b = 1'b1;
            raddr_a = 5'(i); raddr_b = 5'(31 - i);
            step();
            total++;
            if ({a0, b0, a1, b1} !== 128'h0 || {va0, vb0, va1, vb1} !== 4'hF)
                $display("FAIL reset_read[%0d] got %h %h %h %h v=%b want 0 v=f",
                         i, a0, b0, a1, b1, {va0, vb0, va1, vb1});
            else passed++;
        end
        re_a = 1'b0; re_b = 1'b0;
        step();
        total++;
        if ({va0, vb0, va1, vb1} !== 4'b0)
            $display("FAIL rvalid_drop got %b want 0", {va0, vb0, va1, vb1});
        else passed++;
    endtask

    task automatic test_write_read();
        wr(5'd5, 32'hDEADBEEF);
        re_a = 1'b1; raddr_a = 5'd5; re_b = 1'b0; raddr_b = 5'd5;
        step();
        re_a = 1'b0;
        total++;
        if (a0 !== 32'hDEADBEEF || va0 !== 1'b1 || a1 !== 32'hDEADBEEF)
            $display("FAIL write_read got %h/%b %h want deadbeef/1", a0, va0, a1);
        else passed++;
        total++;
        if (b0 !== 32'h0 || vb0 !== 1'b0 || b1 !== 32'h0 || vb1 !== 1'b0)
            $display("FAIL port_b_hold got %h/%b %h/%b want 0/0", b0, vb0, b1, vb1);
        else passed++;
    endtask

    task automatic test_zero_reg();
        wr(5'd0, 32'h12345678);
        re_a = 1'b1; raddr_a = 5'd0;
        step();
        re_a = 1'b0;
        total++;
        if (a0 !== 32'h0)
            $display("FAIL zero_reg_on got %h want 00000000", a0);
        else passed++;
        total++;
        if (a1 !== 32'h12345678)
            $display("FAIL zero_reg_off got %h want 12345678", a1);
        else passed++;
    endtask

    task automatic test_bypass();
        wr(5'd7, 32'h1);
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        re_a = 1'b1; raddr_a = 5'd7; re_b = 1'b1; raddr_b = 5'd7;
        step();
        we = 1'b0;
        total++;
        if (a0 !== 32'hA5A5A5A5 || b0 !== 32'hA5A5A5A5)
            $display("FAIL bypass_on got %h %h want a5a5a5a5", a0, b0);
        else passed++;
        total++;
        if (a1 !== 32'h1 || b1 !== 32'h1)
            $display("FAIL bypass_off got %h %h want 00000001", a1, b1);
        else passed++;
        step();
        re_a = 1'b0; re_b = 1'b0;
        total++;
        if (a1 !== 32'hA5A5A5A5 || b1 !== 32'hA5A5A5A5 || a0 !== 32'hA5A5A5A5)
            $display("FAIL bypass_after got %h %h %h want a5a5a5a5", a1, b1, a0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        wr(5'd3, 32'hFF);
        rst = 1'b1; re_a = 1'b1; raddr_a = 5'd3;
        step();
        rst = 1'b0; re_a = 1'b0;
        total++;
        if (a0 !== 32'h0 || va0 !== 1'b0 || a1 !== 32'h0 || va1 !== 1'b0)
            $display("FAIL reset_mid got %h/%b %h/%b want 0/0", a0, va0, a1, va1);
        else passed++;
        re_a = 1'b1; raddr_a = 5'd3; re_b = 1'b1; raddr_b = 5'd5;
        step();
        re_a = 1'b0; re_b = 1'b0;
        total++;
        if (a0 !== 32'h0 || a1 !== 32'h0 || b0 !== 32'h0 || b1 !== 32'h0)
            $display("FAIL reset_cleared got %h %h %h %h want 0", a0, a1, b0, b1);
        else passed++;
    endtask

    task automatic test_range();
        wr(5'd25, 32'hCAFE);
        re_a = 1'b1; raddr_a = 5'd25;
        step();
        total++;
        if (a1 !== 32'h0 || a0 !== 32'hCAFE)
            $display("FAIL out_of_range got %h %h want 0 0000cafe", a1, a0);
        else passed++;
        wr(5'd19, 32'hBEEF);
        raddr_a = 5'd19;
        step();
        re_a = 1'b0;
        total++;
        if (a1 !== 32'hBEEF || a0 !== 32'hBEEF)
            $display("FAIL last_reg got %h %h want 0000beef", a1, a0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h11111111; vals[1] = 32'h22222222;
        vals[2] = 32'h33333333; vals[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) wr(5'(10 + i), vals[i]);
        re_a = 1'b1; re_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            raddr_a = 5'(10 + i); raddr_b = 5'(13 - i);
            step();
            total++;
            if (a0 !== vals[i] || b0 !== vals[3 - i] ||
                a1 !== vals[i] || b1 !== vals[3 - i] ||
                {va0, vb0, va1, vb1} !== 4'hF)
                $display("FAIL back_to_back[%0d] got %h %h %h %h want %h %h",
                         i, a0, b0, a1, b1, vals[i], vals[3 - i]);
            else passed++;
        end
        re_a = 1'b0; re_b = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_reset_mid();
        test_range();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
